// File: rtl/pic_sample_fifo_if.sv
// pic_sample_fifo_if: PIC-side capture handshake, DAC-side release handshake
// and status/flag signals of pic_sample_fifo. The slave modport is the FIFO
// itself; the master modport is whatever drives the PIC and consumes samples.
interface pic_sample_fifo_if #(
  parameter int LEVEL_W = 4
);
  logic               rx;
  logic [9:0]         pic_data;
  logic               tx;
  logic [11:0]        dac_data;
  logic               dac_valid;
  logic               dac_ready;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overflow;
  logic               underrun;
  logic               clr_flags;

  modport slave (
    input  rx, pic_data, dac_ready, clr_flags,
    output tx, dac_data, dac_valid, fifo_level, overflow, underrun
  );

  modport master (
    output rx, pic_data, dac_ready, clr_flags,
    input  tx, dac_data, dac_valid, fifo_level, overflow, underrun
  );
endinterface

// File: rtl/pic_sample_fifo.sv
// pic_sample_fifo: captures 10-bit PIC samples over the rx/tx level handshake,
// widens them to 12 bits, buffers them in a circular FIFO and releases one
// sample per pacing tick to the SPI stage over valid/ready. Overflow and
// underrun are reported as sticky flags.
module pic_sample_fifo #(
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  pic_sample_fifo_if.slave bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;
  localparam int CNT_W   = $clog2(RATE_DIV);

  localparam logic [LEVEL_W-1:0] LEVEL_FULL  = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
  localparam logic [ADDR_W-1:0]  PTR_ONE     = ADDR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    FULL     = 2'd2
  } state_t;

  // Replicating the two MSBs into the new LSBs maps 0 to 0 and full scale
  // (1023) to full scale (4095) with a monotonic, nearly linear curve.
  function automatic logic [11:0] widen(input logic [9:0] d);
    return {d, d[9:8]};
  endfunction

  // rx synchronizer and one-cycle delayed copy for edge detection
  logic rx_meta;
  logic rx_s;
  logic rx_s_d;

  // capture FSM
  state_t state;
  state_t state_next;
  logic   push;
  logic   tx_next;
  logic   ovf_set;
  logic   tx_hold;

  // FIFO storage and bookkeeping
  logic [11:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               empty;

  // pacing and output stage
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             pop;
  logic             unr_set;
  logic             consume;
  logic [11:0]      out_data;
  logic             out_valid;

  // sticky flags
  logic ovf_flag;
  logic unr_flag;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == LEVEL_EMPTY);
  assign tick  = (cnt == CNT_LAST);

  // Bring the asynchronous rx level into the clk domain; keep the previous
  // synchronized value to spot a fresh rise while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_s_d  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture FSM next-state: accept in IDLE, wait for rx to drop, park in FULL
  // until the output side frees an entry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_s && !full) begin
          state_next = WAIT_LOW;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!rx_s) begin
          if (full) begin
            state_next = FULL;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = WAIT_LOW;
        end
      end
      FULL: begin
        if (!full) begin
          state_next = IDLE;
        end else begin
          state_next = FULL;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture FSM outputs: FIFO write strobe, overflow event and the value tx
  // takes at the next edge (high exactly when the FSM is heading to IDLE).
  always_comb begin
    push    = 1'b0;
    ovf_set = 1'b0;
    tx_next = (state_next == IDLE);
    case (state)
      IDLE: begin
        if (rx_s && !full) begin
          push = 1'b1;
        end else begin
          push = 1'b0;
        end
      end
      WAIT_LOW: begin
        push = 1'b0;
      end
      FULL: begin
        // A new rise while still full is a sample the PIC sent anyway; it is
        // dropped and remembered. If an entry frees up this same cycle the
        // FSM goes back to IDLE and the still-high rx is captured there.
        if (full && rx_s && !rx_s_d) begin
          ovf_set = 1'b1;
        end else begin
          ovf_set = 1'b0;
        end
      end
      default: begin
        push    = 1'b0;
        ovf_set = 1'b0;
      end
    endcase
  end

  // Registered tx so the PIC sees a glitch-free level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold <= 1'b1;
    end else begin
      tx_hold <= tx_next;
    end
  end

  // Free-running pacing counter; tick phase depends only on reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt <= {CNT_W{1'b0}};
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Output-side decisions for this cycle: a tick either pops, reports an
  // underrun, or is ignored because the previous sample is still pending.
  always_comb begin
    pop     = 1'b0;
    unr_set = 1'b0;
    consume = out_valid && bus.dac_ready;
    if (tick && !out_valid) begin
      if (!empty) begin
        pop = 1'b1;
      end else begin
        unr_set = 1'b1;
      end
    end else begin
      pop     = 1'b0;
      unr_set = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the pointers and level
  // define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= widen(bus.pic_data);
    end
  end

  // FIFO pointers (wrap naturally at the power-of-two DEPTH) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {ADDR_W{1'b0}};
      rd_ptr <= {ADDR_W{1'b0}};
      level  <= LEVEL_EMPTY;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Output register: load on pop, drop valid once the SPI stage takes it.
  // dac_data keeps its last value when valid falls or an underrun occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 12'd0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= mem[rd_ptr];
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flags; a set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      unr_flag <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_flag <= 1'b1;
      end else if (bus.clr_flags) begin
        ovf_flag <= 1'b0;
      end
      if (unr_set) begin
        unr_flag <= 1'b1;
      end else if (bus.clr_flags) begin
        unr_flag <= 1'b0;
      end
    end
  end

  assign bus.tx         = tx_hold;
  assign bus.dac_data   = out_data;
  assign bus.dac_valid  = out_valid;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf_flag;
  assign bus.underrun   = unr_flag;

endmodule
